// File: rtl/lz77_pkg.sv
// Shared types and constants for the LZ77 token packer.
// Token bundle layout, record header bits and FSM encoding.
package lz77_pkg;

  localparam int TOKEN_W     = 36;
  localparam int LIT_BYTES   = 2;
  localparam int MATCH_BYTES = 5;

  localparam int HDR_MATCH = 7;
  localparam int HDR_LAST  = 6;
  localparam int HDR_POS16 = 1;
  localparam int HDR_LEN8  = 0;

  typedef struct packed {
    logic [16:0] position;
    logic [8:0]  length;
    logic [7:0]  symbol;
    logic        is_match;
    logic        last;
  } token_t;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    LEN,
    POSH,
    POSL,
    SYM
  } state_t;

  function automatic logic [7:0] header(input token_t t);
    logic [7:0] h;
    h            = '0;
    h[HDR_MATCH] = t.is_match;
    h[HDR_LAST]  = t.last;
    h[HDR_POS16] = t.position[16];
    h[HDR_LEN8]  = t.length[8];
    return h;
  endfunction

endpackage

// File: rtl/lz77_token_fifo.sv
// Synchronous token FIFO with a registered head word.
// rd_data always holds the oldest entry whenever the FIFO is non-empty.
module lz77_token_fifo #(
  parameter int WIDTH     = 36,
  parameter int DEPTH_LOG = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [DEPTH_LOG:0]   count
);

  localparam logic [DEPTH_LOG:0] FULL_CNT =
    {1'b1, {DEPTH_LOG{1'b0}}};

  logic [WIDTH-1:0]     mem [0:(1<<DEPTH_LOG)-1];
  logic [DEPTH_LOG-1:0] wr_ptr;
  logic [DEPTH_LOG-1:0] rd_ptr;
  logic [DEPTH_LOG-1:0] rd_nxt;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_nxt  = rd_ptr + DEPTH_LOG'(do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_nxt;
      count  <= count
              + (DEPTH_LOG+1)'(do_push)
              - (DEPTH_LOG+1)'(do_pop);
      // a write landing on the next head slot is forwarded
      if (do_push && (wr_ptr == rd_nxt))
        rd_data <= wr_data;
      else
        rd_data <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/lz77_token_packer.sv
// Serializes LZ77 tokens into 2-byte literal / 5-byte match records.
// Registered byte output with valid/ready backpressure.
import lz77_pkg::*;

module lz77_token_packer #(
  parameter int DATA_WIDTH           = 8,
  parameter int DICTIONARY_DEPTH_LOG = 16,
  parameter int CNT_WIDTH            = 9,
  parameter int FIFO_DEPTH_LOG       = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_token_valid,
  input  logic [DICTIONARY_DEPTH_LOG:0] in_match_position,
  input  logic [CNT_WIDTH-1:0]          in_match_length,
  input  logic [DATA_WIDTH-1:0]         in_match_next_symbol,
  input  logic                          in_match_valid,
  input  logic                          in_last_symbol,
  output logic                          in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic                          overflow
);

  localparam logic [FIFO_DEPTH_LOG:0] FULL_CNT =
    {1'b1, {FIFO_DEPTH_LOG{1'b0}}};

  token_t                  wr_tok;
  token_t                  rd_tok;
  token_t                  hold;
  token_t                  hold_nxt;
  state_t                  state;
  state_t                  state_nxt;
  logic                    push;
  logic                    pop;
  logic                    full;
  logic                    empty;
  logic [FIFO_DEPTH_LOG:0] count;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic                    valid_nxt;
  logic                    last_nxt;
  logic                    acc;

  assign wr_tok.position = in_match_position;
  assign wr_tok.length   = in_match_length;
  assign wr_tok.symbol   = in_match_next_symbol;
  assign wr_tok.is_match = in_match_valid;
  assign wr_tok.last     = in_last_symbol;

  assign in_ready = (count != FULL_CNT);
  assign push     = in_token_valid & in_ready;
  assign acc      = out_valid & out_ready;

  lz77_token_fifo #(
    .WIDTH     (TOKEN_W),
    .DEPTH_LOG (FIFO_DEPTH_LOG)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_tok),
    .pop     (pop),
    .rd_data (rd_tok),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    state_nxt = state;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    last_nxt  = out_last;
    hold_nxt  = hold;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          hold_nxt  = rd_tok;
          state_nxt = HDR;
          data_nxt  = header(rd_tok);
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
        end
      end
      HDR: begin
        if (acc) begin
          if (hold.is_match) begin
            state_nxt = LEN;
            data_nxt  = hold.length[7:0];
          end else begin
            state_nxt = SYM;
            data_nxt  = hold.symbol;
            last_nxt  = hold.last;
          end
        end
      end
      LEN: begin
        if (acc) begin
          state_nxt = POSH;
          data_nxt  = hold.position[15:8];
        end
      end
      POSH: begin
        if (acc) begin
          state_nxt = POSL;
          data_nxt  = hold.position[7:0];
        end
      end
      POSL: begin
        if (acc) begin
          state_nxt = SYM;
          data_nxt  = hold.symbol;
          last_nxt  = hold.last;
        end
      end
      SYM: begin
        if (acc) begin
          last_nxt = 1'b0;
          // chain straight into the next record when one is queued
          if (!empty) begin
            pop       = 1'b1;
            hold_nxt  = rd_tok;
            state_nxt = HDR;
            data_nxt  = header(rd_tok);
          end else begin
            state_nxt = IDLE;
            data_nxt  = '0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        data_nxt  = '0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      hold      <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      out_last  <= last_nxt;
      hold      <= hold_nxt;
      if (in_token_valid && full) overflow <= 1'b1;
    end
  end

endmodule
